// File: rtl/msrv_32_pkg.sv
// Shared types for the msrv_32 load/store path: size codes, AHB htrans codes
// and the store-unit FSM state encoding.
package msrv_32_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_WORD_X = 2'b11
    } size_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

endpackage

// File: rtl/msrv_32_store_lane_align.sv
// Byte-lane replication and strobe generation for stores.
// MSRV32_STORE_MISALIGN_TRAP_EN enables the misaligned-access flag.
module msrv_32_store_lane_align
    import msrv_32_pkg::*;
(
    input  logic [1:0]  size_in,
    input  logic [1:0]  offset_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  mask_out,
    output logic        misaligned_out
);

    size_e size;
    assign size = size_e'(size_in);

    always_comb begin
        data_out = data_in;
        mask_out = 4'b1111;
        unique case (size)
            SIZE_BYTE: begin
                data_out = {4{data_in[7:0]}};
                mask_out = 4'b0001 << offset_in;
            end
            SIZE_HALF: begin
                data_out = {2{data_in[15:0]}};
                mask_out = 4'b0011 << {offset_in[1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef MSRV32_STORE_MISALIGN_TRAP_EN
    always_comb begin
        misaligned_out = 1'b0;
        if (size == SIZE_HALF)
            misaligned_out = offset_in[0];
        else if (size != SIZE_BYTE)
            misaligned_out = |offset_in;
    end
`else
    assign misaligned_out = 1'b0;
`endif

endmodule

// File: rtl/msrv_32_store_unit.sv
// AHB-lite store unit: IDLE -> ADDR -> DATA with stall timeout.
// Optional misalignment trap via MSRV32_STORE_MISALIGN_TRAP_EN.
module msrv_32_store_unit
    import msrv_32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        ms_risc32_mp_clk_in,
    input  logic        ms_risc32_mp_rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  store_size_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ahb_ready_in,
    input  logic        ahb_resp_in,
    output logic [31:0] ms_risc32_mp_dmaddr_out,
    output logic [31:0] ms_risc32_mp_dmdata_out,
    output logic [3:0]  ms_risc32_mp_dmwr_mask_out,
    output logic        ms_risc32_mp_dmwr_req_out,
    output logic [1:0]  ahb_htrans_out,
    output logic        store_busy_out,
    output logic        store_done_out,
    output logic        store_err_out
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
    localparam bit         TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] lane_data;
    logic [3:0]  lane_mask;
    logic        lane_misaligned;
    logic [7:0]  cnt_inc;
    logic        stall_expired;

    msrv_32_store_lane_align u_lane (
        .size_in        (store_size_in),
        .offset_in      (iadder_in[1:0]),
        .data_in        (rs2_in),
        .data_out       (lane_data),
        .mask_out       (lane_mask),
        .misaligned_out (lane_misaligned)
    );

    assign cnt_inc       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign stall_expired = TIMEOUT_EN && !ahb_ready_in && (cnt_inc == TIMEOUT_LIM);

    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
        if (!ms_risc32_mp_rst_in)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (store_req_in && !lane_misaligned) state_d = ST_ADDR;
            ST_ADDR: begin
                if (ahb_ready_in)
                    state_d = ST_DATA;
                else if (stall_expired)
                    state_d = ST_IDLE;
            end
            ST_DATA: if (ahb_ready_in || stall_expired) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall counter restarts on every state change; idle keeps it at zero.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        mask_d = mask_q;
        cnt_d  = (state_d != state_q) ? 8'd0 : (ahb_ready_in ? cnt_q : cnt_inc);
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (store_req_in) begin
                    if (lane_misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = {iadder_in[31:2], 2'b00};
                        data_d = lane_data;
                        mask_d = lane_mask;
                    end
                end
            end
            ST_ADDR: err_d = stall_expired;
            ST_DATA: begin
                done_d = ahb_ready_in && !ahb_resp_in;
                err_d  = (ahb_ready_in && ahb_resp_in) || stall_expired;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
        if (!ms_risc32_mp_rst_in) begin
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        ahb_htrans_out            = HTRANS_IDLE;
        ms_risc32_mp_dmwr_req_out = 1'b0;
        store_busy_out            = 1'b0;
        unique case (state_q)
            ST_ADDR: begin
                ahb_htrans_out            = HTRANS_NONSEQ;
                ms_risc32_mp_dmwr_req_out = 1'b1;
                store_busy_out            = 1'b1;
            end
            ST_DATA: store_busy_out = 1'b1;
            default: ;
        endcase
    end

    assign ms_risc32_mp_dmaddr_out    = addr_q;
    assign ms_risc32_mp_dmdata_out    = data_q;
    assign ms_risc32_mp_dmwr_mask_out = mask_q;
    assign store_done_out             = done_q;
    assign store_err_out              = err_q;

endmodule
